cmt_prog_ctrl: RTL and testbench

//  Serial programming master for the DCM_CLKGEN M/D reprogramming port of the programmable

---
 rtl/cmt_prog_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_cmt_prog_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/cmt_prog_ctrl.sv
// cmt_prog_ctrl: serial programming master for the DCM_CLKGEN M/D port.
// Accepts an M/D request, shifts LoadD / LoadM / GO on progen/progdata,
// waits for the DCM to report completion, then holds pll_reset so the
// downstream PLL relocks.
// Ports:
//   progclk, rst_n      clock (also DCM PROGCLK), async active-low reset
//   start               request programming, sampled only in IDLE
//   m_val, d_val        requested multiplier (2..256) / divider (1..256)
//   progdone_inv        low = DCM programming complete
//   progen, progdata    DCM programming interface
//   pll_reset           PLL reset, sticky after a timeout
//   busy                high whenever not IDLE
//   done, err           one-cycle completion / failure pulses
module cmt_prog_ctrl #(
  parameter int unsigned TIMEOUT     = 65535,
  parameter int unsigned PLL_RST_LEN = 16
) (
  input  logic       progclk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [8:0] m_val,
  input  logic [8:0] d_val,
  input  logic       progdone_inv,
  output logic       progen,
  output logic       progdata,
  output logic       pll_reset,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(9);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(PLL_RST_LEN - 1);
  localparam logic [CNT_W-1:0] GUARD     = CNT_W'(2);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_D, S_GAP_D, S_LOAD_M, S_GAP_M, S_GO, S_WAIT_DONE, S_PLL_RST
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       dm1_q, dm1_d, mm1_q, mm1_d;
  logic             progen_q, progen_d, progdata_q, progdata_d;
  logic             pll_reset_q, pll_reset_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic             legal_c;
  logic [2:0]       bit_idx_c;

  assign legal_c = (m_val >= 9'd2) && (m_val <= 9'd256) &&
                   (d_val != 9'd0) && (d_val <= 9'd256);

  // Payload bit for the next serial slot: slot n>=2 carries byte bit n-2 = cnt_q-1.
  assign bit_idx_c = 3'(cnt_q - CNT_W'(1));

  // State register and registered outputs
  always_ff @(posedge progclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dm1_q       <= '0;
      mm1_q       <= '0;
      progen_q    <= 1'b0;
      progdata_q  <= 1'b0;
      pll_reset_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dm1_q       <= dm1_d;
      mm1_q       <= mm1_d;
      progen_q    <= progen_d;
      progdata_q  <= progdata_d;
      pll_reset_q <= pll_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Next state; outputs are computed for the cycle after the edge
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dm1_d       = dm1_q;
    mm1_d       = mm1_q;
    progen_d    = 1'b0;
    progdata_d  = 1'b0;
    pll_reset_d = pll_reset_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (legal_c) begin
            dm1_d       = 8'(d_val - 9'd1);
            mm1_d       = 8'(m_val - 9'd1);
            state_d     = S_LOAD_D;
            cnt_d       = '0;
            progen_d    = 1'b1;
            progdata_d  = 1'b1;
            pll_reset_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD_D: begin
        if (cnt_q == LOAD_LAST) begin
          state_d = S_GAP_D;
          cnt_d   = '0;
        end else begin
          cnt_d      = cnt_q + CNT_W'(1);
          progen_d   = 1'b1;
          progdata_d = (cnt_q == '0) ? 1'b0 : dm1_q[bit_idx_c];
        end
      end
      S_GAP_D: begin
        state_d    = S_LOAD_M;
        cnt_d      = '0;
        progen_d   = 1'b1;
        progdata_d = 1'b1;
      end
      S_LOAD_M: begin
        if (cnt_q == LOAD_LAST) begin
          state_d = S_GAP_M;
          cnt_d   = '0;
        end else begin
          cnt_d      = cnt_q + CNT_W'(1);
          progen_d   = 1'b1;
          progdata_d = (cnt_q == '0) ? 1'b1 : mm1_q[bit_idx_c];
        end
      end
      S_GAP_M: begin
        state_d  = S_GO;
        progen_d = 1'b1;
      end
      S_GO: begin
        state_d = S_WAIT_DONE;
        cnt_d   = '0;
      end
      S_WAIT_DONE: begin
        // Done is ignored for the first two cycles; done beats timeout on a tie.
        if ((cnt_q >= GUARD) && !progdone_inv) begin
          state_d = S_PLL_RST;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PLL_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d     = S_IDLE;
          cnt_d       = '0;
          pll_reset_d = 1'b0;
          done_d      = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign progen    = progen_q;
  assign progdata  = progdata_q;
  assign pll_reset = pll_reset_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_cmt_prog_ctrl.sv
// Testbench for cmt_prog_ctrl: expected per-cycle outputs are queued as
// stimulus is driven and compared one per cycle on the falling edge.
module tb_cmt_prog_ctrl;

  localparam int unsigned TIMEOUT     = 100;
  localparam int unsigned PLL_RST_LEN = 16;

  logic       progclk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [8:0] m_val, d_val;
  logic       progdone_inv;
  logic       progen, progdata, pll_reset, busy, done, err;

  cmt_prog_ctrl #(.TIMEOUT(TIMEOUT), .PLL_RST_LEN(PLL_RST_LEN)) dut (
    .progclk(progclk), .rst_n(rst_n), .start(start), .m_val(m_val), .d_val(d_val),
    .progdone_inv(progdone_inv), .progen(progen), .progdata(progdata),
    .pll_reset(pll_reset), .busy(busy), .done(done), .err(err)
  );

  always #5 progclk = ~progclk;

  typedef struct packed {
    logic progen, progdata, pll_reset, busy, done, err;
  } obs_t;

  typedef struct {
    logic [8:0] m, d;
    bit         legal;
    logic [7:0] db, mb;
  } vec_t;

  obs_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_cyc  = 0;
  logic sticky_pr = 1'b0;

  function automatic obs_t mk(logic pe, logic pd, logic pr, logic bs, logic dn, logic er);
    mk = {pe, pd, pr, bs, dn, er};
  endfunction

  function automatic obs_t act();
    act = {progen, progdata, pll_reset, busy, done, err};
  endfunction

  // Expected outputs for cycle t+c of a programming sequence started at edge t.
  function automatic obs_t exp_prog(int c, logic [7:0] db, logic [7:0] mb);
    logic b;
    if (c <= 10) begin
      b = (c == 1) ? 1'b1 : (c == 2) ? 1'b0 : db[3'(c - 3)];
      exp_prog = mk(1'b1, b, 1'b1, 1'b1, 1'b0, 1'b0);
    end else if (c == 11 || c == 22) begin
      exp_prog = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    end else if (c <= 21) begin
      b = (c == 12) ? 1'b1 : (c == 13) ? 1'b1 : mb[3'(c - 14)];
      exp_prog = mk(1'b1, b, 1'b1, 1'b1, 1'b0, 1'b0);
    end else begin
      exp_prog = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    end
  endfunction

  task automatic check_now(input string tag, input obs_t e);
    obs_t a;
    a = act();
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %b want %b (pe pd pr busy done err)", tag, n_cyc, a, e);
    end
  endtask

  // Advance one clock and compare against the oldest queued expectation.
  task automatic cycle(input string tag);
    @(posedge progclk);
    @(negedge progclk);
    n_cyc++;
    if (exp_q.size() > 0) check_now(tag, exp_q.pop_front());
  endtask

  task automatic expect_cycle(input string tag, input obs_t e);
    exp_q.push_back(e);
    cycle(tag);
  endtask

  // Start a sequence and run n_cycles of it; extra start pulses while busy if asked.
  task automatic prog_seq(input logic [8:0] m, input logic [8:0] d, input logic [7:0] db,
                          input logic [7:0] mb, input int n_cycles, input bit busy_starts);
    start = 1'b1; m_val = m; d_val = d;
    for (int c = 1; c <= n_cycles; c++) begin
      exp_q.push_back(exp_prog(c, db, mb));
      cycle("prog");
      start = busy_starts && (c % 4 == 1);
      m_val = 9'($urandom);
      d_val = 9'($urandom);
    end
    start = 1'b0;
  endtask

  // WAIT_DONE and PLL_RST phases; progdone_inv low at cycle glitch_at and from low_at on.
  task automatic wait_phase(input int low_at, input int glitch_at);
    logic pdi;
    bit   timed_out;
    timed_out = 1'b0;
    expect_cycle("wait_entry", mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < int'(TIMEOUT); i++) begin
      pdi = !(i == glitch_at || i >= low_at);
      progdone_inv = pdi;
      if (i >= 2 && !pdi) begin
        expect_cycle("pll_rst_entry", mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
        break;
      end else if (i == int'(TIMEOUT) - 1) begin
        expect_cycle("timeout_err", mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
        timed_out = 1'b1;
        break;
      end else begin
        expect_cycle("wait", mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
      end
    end
    progdone_inv = 1'b1;
    if (timed_out) begin
      sticky_pr = 1'b1;
      repeat (3) expect_cycle("timeout_idle", mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    end else begin
      for (int j = 1; j < int'(PLL_RST_LEN); j++)
        expect_cycle("pll_rst", mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
      expect_cycle("done_pulse", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
      expect_cycle("post_done", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      sticky_pr = 1'b0;
    end
  endtask

  task automatic illegal(input logic [8:0] m, input logic [8:0] d);
    start = 1'b1; m_val = m; d_val = d;
    expect_cycle("illegal_err", mk(1'b0, 1'b0, sticky_pr, 1'b0, 1'b0, 1'b1));
    start = 1'b0;
    repeat (3) expect_cycle("illegal_idle", mk(1'b0, 1'b0, sticky_pr, 1'b0, 1'b0, 1'b0));
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{m: 9'd20,  d: 9'd27,  legal: 1'b1, db: 8'd26,  mb: 8'd19};
    vecs[1] = '{m: 9'd1,   d: 9'd5,   legal: 1'b0, db: 8'd0,   mb: 8'd0};
    vecs[2] = '{m: 9'd256, d: 9'd256, legal: 1'b1, db: 8'hFF,  mb: 8'hFF};
    vecs[3] = '{m: 9'd257, d: 9'd10,  legal: 1'b0, db: 8'd0,   mb: 8'd0};
    vecs[4] = '{m: 9'd2,   d: 9'd1,   legal: 1'b1, db: 8'h00,  mb: 8'h01};
    vecs[5] = '{m: 9'd5,   d: 9'd0,   legal: 1'b0, db: 8'd0,   mb: 8'd0};
    vecs[6] = '{m: 9'd7,   d: 9'd257, legal: 1'b0, db: 8'd0,   mb: 8'd0};
    vecs[7] = '{m: 9'd0,   d: 9'd3,   legal: 1'b0, db: 8'd0,   mb: 8'd0};
    vecs[8] = '{m: 9'd100, d: 9'd3,   legal: 1'b1, db: 8'h02,  mb: 8'h63};

    rst_n = 1'b0; start = 1'b0; m_val = '0; d_val = '0; progdone_inv = 1'b1;
    repeat (3) @(posedge progclk);
    @(negedge progclk);
    check_now("reset_state", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    rst_n = 1'b1;
    expect_cycle("idle_after_reset", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    // Legal and illegal M/D pairs, done arriving 5 cycles into WAIT_DONE
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].legal) begin
        prog_seq(vecs[i].m, vecs[i].d, vecs[i].db, vecs[i].mb, 23, (i % 2) == 0);
        wait_phase(5, -1);
      end else begin
        illegal(vecs[i].m, vecs[i].d);
      end
    end

    // Timeout: done never arrives; pll_reset stays high, later err keeps it
    prog_seq(9'd20, 9'd27, 8'd26, 8'd19, 23, 1'b0);
    wait_phase(1 << 30, -1);
    illegal(9'd1, 9'd5);

    // Stale done on the first WAIT_DONE cycle is ignored; later done completes
    prog_seq(9'd20, 9'd27, 8'd26, 8'd19, 23, 1'b0);
    wait_phase(8, 0);

    // Mid-sequence reset at t+15 drops everything immediately
    prog_seq(9'd20, 9'd27, 8'd26, 8'd19, 15, 1'b0);
    rst_n = 1'b0;
    #1;
    check_now("async_reset", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(posedge progclk);
    @(negedge progclk);
    rst_n = 1'b1;
    repeat (2) expect_cycle("idle_after_abort", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    sticky_pr = 1'b0;

    // Restart with extra start pulses while busy
    prog_seq(9'd20, 9'd27, 8'd26, 8'd19, 23, 1'b1);
    wait_phase(5, -1);

    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover want 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
